// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier (seq_mul_n).
// Holds the controller state type and the step-counter width helpers.
package mul_pkg;

  // Controller states: idle, shift-add steps, sign fix-up, result presented.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Operand width of the execution-unit instance and its step-counter width.
  localparam int unsigned DEFAULT_N = 32;
  localparam int unsigned CNT_W     = $clog2(DEFAULT_N);

  // Step-counter width for an arbitrary operand width: counts 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Combinational two's-complement negate-if: y = neg ? -a : a (modulo 2^W).
// Used for operand magnitudes (W=N) and for the final sign fix (W=2N).
module cond_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/seq_mul_n.sv
// Iterative shift-add multiplier: N x N -> 2N bits, signed or unsigned per op.
// Operation: magnitudes are multiplied over N CALC steps, the sign is applied
// in FIX, and the result is presented in DONE until acknowledged.
// Handshake: an op is accepted on an edge where start=1 and the block is IDLE,
// or is DONE with ack=1 (back-to-back). ready=1 marks a valid result; the
// consumer takes it by holding ack=1 for one edge. ack while ready=0 is ignored.
// Optional feature macro MUL_EARLY_TERM_EN: CALC ends as soon as the remaining
// multiplier bits are all zero (same result, shorter latency).
module seq_mul_n
  import mul_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] multiplier,
  input  logic [N-1:0] multiplicand,
  input  logic         ack,
  output logic         busy,
  output logic         ready,
  output logic [N-1:0] product_upper,
  output logic [N-1:0] product_lower,
  output state_t       dbg_state
);

  localparam int CW = cnt_width(N);

  state_t         state;
  logic [N-1:0]   m;
  logic [2*N-1:0] b_sh;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] result;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic           accept;
  logic           calc_last;
  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [2*N-1:0] fix_val;

  // |multiplier| and |multiplicand| when signed; raw operands otherwise.
  cond_negate #(.W(N)) u_neg_a (
    .neg (signed_mode & multiplier[N-1]),
    .a   (multiplier),
    .y   (mag_a)
  );

  cond_negate #(.W(N)) u_neg_b (
    .neg (signed_mode & multiplicand[N-1]),
    .a   (multiplicand),
    .y   (mag_b)
  );

  // Apply the product sign to the accumulated magnitude.
  cond_negate #(.W(2*N)) u_neg_fix (
    .neg (neg),
    .a   (acc),
    .y   (fix_val)
  );

  assign accept = start && ((state == IDLE) || ((state == DONE) && ack));

`ifdef MUL_EARLY_TERM_EN
  // Stop once N steps are done or no set multiplier bits remain after this step.
  assign calc_last = (cnt == CW'(N - 1)) || ((m >> 1) == '0);
`else
  // Always run exactly N steps.
  assign calc_last = (cnt == CW'(N - 1));
`endif

  // Controller and datapath: state transitions, shift-add steps, result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      m      <= '0;
      b_sh   <= '0;
      acc    <= '0;
      result <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        CALC: begin
          if (m[0]) acc <= acc + b_sh;
          b_sh <= b_sh << 1;
          m    <= m >> 1;
          cnt  <= cnt + CW'(1);
          if (calc_last) state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          state  <= DONE;
        end
        DONE: begin
          if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A new op overrides the IDLE hold or the DONE->IDLE return.
      if (accept) begin
        m     <= mag_a;
        b_sh  <= {{N{1'b0}}, mag_b};
        acc   <= '0;
        cnt   <= '0;
        neg   <= signed_mode & (multiplier[N-1] ^ multiplicand[N-1]);
        state <= CALC;
      end
    end
  end

  assign busy          = (state == CALC) || (state == FIX);
  assign ready         = (state == DONE);
  assign product_upper = result[2*N-1:N];
  assign product_lower = result[N-1:0];
  assign dbg_state     = state;

endmodule

// File: tb/tb_seq_mul_n.sv
// Self-checking bench for seq_mul_n (N=32): vector table, handshake corner
// sequences, and randomized ops checked against an arithmetic reference model.
// Build with MUL_EARLY_TERM_EN defined to check the shortened latency.
module tb_seq_mul_n;
  import mul_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_mode;
  logic [N-1:0] multiplier;
  logic [N-1:0] multiplicand;
  logic         ack;
  logic         busy;
  logic         ready;
  logic [N-1:0] product_upper;
  logic [N-1:0] product_lower;
  state_t       dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*N-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           sm;
    logic [2*N-1:0] p;
  } vec_t;

  vec_t vecs[10];

  seq_mul_n #(.N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .signed_mode   (signed_mode),
    .multiplier    (multiplier),
    .multiplicand  (multiplicand),
    .ack           (ack),
    .busy          (busy),
    .ready         (ready),
    .product_upper (product_upper),
    .product_lower (product_lower),
    .dbg_state     (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference product: plain integer arithmetic modulo 2^64.
  function automatic logic [63:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic sm);
    longint sa, sb;
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    return 64'(sa * sb);
  endfunction

  // Reference latency in cycles from the accepting edge to ready.
  function automatic int ref_lat(input logic [N-1:0] a, input logic sm);
`ifdef MUL_EARLY_TERM_EN
    logic [N-1:0] mag;
    int hi;
    mag = (sm && a[N-1]) ? (32'd0 - a) : a;
    hi = 0;
    for (int i = 0; i < N; i++) if (mag[i]) hi = i + 1;
    if (hi < 1) hi = 1;
    return hi + 1;
`else
    if (sm) return N + 1;
    if (a == 0) return N + 1;
    return N + 1;
`endif
  endfunction

  // Drive one accepted op; with_ack makes it a back-to-back issue from DONE.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm,
                          input logic [63:0] exp, input bit with_ack, input string name);
    multiplier   = a;
    multiplicand = b;
    signed_mode  = sm;
    start        = 1'b1;
    ack          = with_ack;
    @(posedge clk);
    #1;
    start        = 1'b0;
    ack          = 1'b0;
    multiplier   = $urandom;
    multiplicand = $urandom;
    signed_mode  = 1'($urandom_range(0, 1));
    exp_q.push_back(exp);
    check({name, "_busy_after_accept"}, 64'(busy), 64'd1);
  endtask

  // Count edges until ready (pre = edges already spent since accept).
  task automatic wait_result(input string name, input int exp_lat, input int pre);
    int cyc;
    logic [63:0] exp;
    cyc = pre;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
    while (1) begin
      if (cyc >= 200) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: no ready after %0d cycles, want %0d", name, cyc, exp_lat);
        return;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (ready) break;
    end
    check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({name, "_product"}, {product_upper, product_lower}, exp);
    check({name, "_busy_at_ready"}, 64'(busy), 64'd0);
  endtask

  task automatic ack_op(input string name);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    check({name, "_ready_after_ack"}, 64'(ready), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic [N-1:0] ra, rb;
    logic rsm;
    bit pending;

    vecs[0] = '{32'd3,         32'd3,         1'b0, 64'd9};
    vecs[1] = '{32'hFFFFFFFF,  32'd1,         1'b1, 64'hFFFFFFFF_FFFFFFFF};
    vecs[2] = '{32'h80000000,  32'h80000000,  1'b1, 64'h40000000_00000000};
    vecs[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'hFFFFFFFE_00000001};
    vecs[4] = '{32'd7,         32'd6,         1'b0, 64'd42};
    vecs[5] = '{32'hFFFFFFFE,  32'd3,         1'b1, 64'hFFFFFFFF_FFFFFFFA};
    vecs[6] = '{32'd0,         32'hFFFFFFFF,  1'b0, 64'd0};
    vecs[7] = '{32'h80000000,  32'd2,         1'b0, 64'h00000001_00000000};
    vecs[8] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h00000000_80000000};
    vecs[9] = '{32'h7FFFFFFF,  32'h80000000,  1'b1, 64'hC0000000_80000000};

    // Reset
    reset = 1'b0; start = 1'b0; ack = 1'b0; signed_mode = 1'b0;
    multiplier = '0; multiplicand = '0;
    #12;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_product", {product_upper, product_lower}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // 3x3, then ack and confirm the result persists in IDLE
    start_op(32'd3, 32'd3, 1'b0, 64'd9, 1'b0, "first");
    wait_result("first", ref_lat(32'd3, 1'b0), 0);
    ack_op("first");
    repeat (3) @(posedge clk);
    #1;
    check("idle_holds_product", {product_upper, product_lower}, 64'd9);
    check("idle_state", 64'(dbg_state), 64'(IDLE));

    // Vector table
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].p, 1'b0, $sformatf("vec%0d", i));
      wait_result($sformatf("vec%0d", i), ref_lat(vecs[i].a, vecs[i].sm), 0);
      ack_op($sformatf("vec%0d", i));
    end

    // start (with ack) pulsed during CALC is ignored; old result held meanwhile
    held = {product_upper, product_lower};
    start_op(32'h00FF0011, 32'd13, 1'b0, ref_prod(32'h00FF0011, 32'd13, 1'b0), 1'b0, "ign");
    repeat (3) begin @(posedge clk); #1; end
    check("ign_hold_in_calc", {product_upper, product_lower}, held);
    multiplier = 32'd2; multiplicand = 32'd2; start = 1'b1; ack = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; ack = 1'b0;
    wait_result("ign", ref_lat(32'h00FF0011, 1'b0), 4);

    // DONE held 5 cycles without ack, then back-to-back 7x6
    held = {product_upper, product_lower};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_ready_%0d", i), 64'(ready), 64'd1);
      check($sformatf("hold_product_%0d", i), {product_upper, product_lower}, held);
    end
    start_op(32'd7, 32'd6, 1'b0, 64'd42, 1'b1, "b2b");
    check("b2b_ready_dropped", 64'(ready), 64'd0);
    check("b2b_old_result_held", {product_upper, product_lower}, held);
    wait_result("b2b", ref_lat(32'd7, 1'b0), 0);
    ack_op("b2b");

    // Asynchronous reset at CALC step 10
    start_op(32'h00012345, 32'h00000777, 1'b0, 64'd0, 1'b0, "rst");
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", {product_upper, product_lower}, 64'd0);
    exp_q.delete();
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_state_idle", 64'(dbg_state), 64'(IDLE));
    start_op(32'd5, 32'd5, 1'b0, 64'd25, 1'b0, "post_rst");
    wait_result("post_rst", ref_lat(32'd5, 1'b0), 0);

    // Randomized ops, mixed back-to-back and idle gaps
    pending = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rsm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) ra = ra >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 0) begin
        start_op(ra, rb, rsm, ref_prod(ra, rb, rsm), 1'b1, "rnd");
      end else begin
        ack_op("rnd");
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        start_op(ra, rb, rsm, ref_prod(ra, rb, rsm), 1'b0, "rnd");
      end
      wait_result($sformatf("rnd%0d", i), ref_lat(ra, rsm), 0);
    end
    if (pending) ack_op("last");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
